// File: rtl/lab22_d_ff.sv
// lab22_d_ff
//   Positive-edge D-type storage register with asynchronous active-high reset.
//   Registers a WIDTH-bit data vector onto clk and provides its complement.
//
// Ports
//   clk     in   1      system clock, captures on rising edge
//   rst     in   1      asynchronous reset, active-high (tie to 1'b0 if unused)
//   D_in    in   WIDTH  data to capture
//   q_out   out  WIDTH  registered data
//   qn_out  out  WIDTH  bitwise complement of q_out
module lab22_d_ff #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D_in,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] qn_out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_out <= RESET_VAL;
    end else begin
      q_out <= D_in;
    end
  end

  // Derived from q_out rather than stored, so it can never disagree with it.
  assign qn_out = ~q_out;

endmodule

// File: tb/tb_lab22_d_ff.sv
`timescale 1ns/1ps
module tb_lab22_d_ff;

  logic       clk;
  logic       rst;
  logic       d1;
  logic       q1;
  logic       qn1;

  logic       rst8;
  logic [7:0] d8;
  logic [7:0] q8;
  logic [7:0] qn8;

  int vectors;
  int miscompares;

  lab22_d_ff dut1 (
    .clk    (clk),
    .rst    (rst),
    .D_in   (d1),
    .q_out  (q1),
    .qn_out (qn1)
  );

  lab22_d_ff #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .clk    (clk),
    .rst    (rst8),
    .D_in   (d8),
    .q_out  (q8),
    .qn_out (qn8)
  );

  // Rising edges at 5, 15, 25, ...; clk is low during [10k, 10k+5).
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst  = 1'b0;
    d1   = 1'b0;
    rst8 = 1'b0;
    d8   = 8'h00;

    // Free-running: D toggles every 10 ns from 0, checked 1 ns after each edge.
    #6;  check("free_5_q",  64'(q1), 64'd0); check("free_5_qn",  64'(qn1), 64'd1);
    #4;  d1 = 1'b1;
    #6;  check("free_15_q", 64'(q1), 64'd1); check("free_15_qn", 64'(qn1), 64'd0);
    #4;  d1 = 1'b0;
    #6;  check("free_25_q", 64'(q1), 64'd0); check("free_25_qn", 64'(qn1), 64'd1);
    #4;  d1 = 1'b1;
    #6;  check("free_35_q", 64'(q1), 64'd1); check("free_35_qn", 64'(qn1), 64'd0);
    #4;  d1 = 1'b0;
    #6;  check("free_45_q", 64'(q1), 64'd0); check("free_45_qn", 64'(qn1), 64'd1);
    #4;  d1 = 1'b1;                                   // t=50
    #6;  check("pre_rst_q", 64'(q1), 64'd1);          // t=56, after edge 55

    // Async reset raised at t=62 with clk low.
    #6;  rst = 1'b1;                                  // t=62
    #1;  check("async_rst_q",  64'(q1), 64'd0);       // t=63, before edge 65
         check("async_rst_qn", 64'(qn1), 64'd1);

    // Reset dominance over edges 65, 75, 85 with D=1.
    #3;  check("rst_dom_65", 64'(q1), 64'd0);         // t=66
    #10; check("rst_dom_75", 64'(q1), 64'd0);         // t=76
    #10; check("rst_dom_85", 64'(q1), 64'd0);         // t=86

    // Release between edges at t=92; first capture at edge 95.
    #6;  rst = 1'b0;                                  // t=92
    #1;  check("release_hold", 64'(q1), 64'd0);       // t=93
    #3;  check("release_cap",  64'(q1), 64'd1);       // t=96
         check("release_qn",   64'(qn1), 64'd0);

    // Glitches on D between edges 95 and 105, ending at 0; clk falls at 100.
    #1;  d1 = 1'b0;                                   // t=97
    #2;  d1 = 1'b1;                                   // t=99
    #1;  check("glitch_mid", 64'(q1), 64'd1);         // t=100
    #1;  d1 = 1'b0;                                   // t=101
    #1;  d1 = 1'b1;                                   // t=102
    #1;  d1 = 1'b0;                                   // t=103
    #1;  check("glitch_pre", 64'(q1), 64'd1);         // t=104
    #2;  check("glitch_cap", 64'(q1), 64'd0);         // t=106

    // Falling edge at 110 must not capture; rising edge at 115 does.
    #1;  d1 = 1'b1;                                   // t=107
    #4;  check("negedge_hold", 64'(q1), 64'd0);       // t=111
    #5;  check("posedge_cap",  64'(q1), 64'd1);       // t=116

    // 8-bit instance, RESET_VAL = A5.
    #4;  rst8 = 1'b1; d8 = 8'h3C;                     // t=120
    #1;  check("w8_rst_q",  64'(q8), 64'hA5);         // t=121
         check("w8_rst_qn", 64'(qn8), 64'h5A);
    #5;  check("w8_rst_dom", 64'(q8), 64'hA5);        // t=126, after edge 125
    #2;  rst8 = 1'b0;                                 // t=128
    #1;  check("w8_release_hold", 64'(q8), 64'hA5);   // t=129
    #7;  check("w8_cap_q",  64'(q8), 64'h3C);         // t=136, after edge 135
         check("w8_cap_qn", 64'(qn8), 64'hC3);
    #1;  d8 = 8'hFF;                                  // t=137
    #9;  check("w8_ff_q",  64'(q8), 64'hFF);          // t=146
         check("w8_ff_qn", 64'(qn8), 64'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
